// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron sequencer.
// Build option: PERCEPTRON_SIGNED_EN selects two's-complement arithmetic.
package perceptron_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAcc,
      StCmp
   } state_e;

   localparam int unsigned NInDefault  = 8;
   localparam int unsigned WWDefault   = 4;
   localparam int unsigned AccWDefault = 8;

`ifdef PERCEPTRON_SIGNED_EN
   localparam bit SignedEn = 1'b1;
`else
   localparam bit SignedEn = 1'b0;
`endif

   // Upper clamp value for an acc_w-bit accumulator, as a 32-bit pattern.
   function automatic logic [31:0] sat_hi(input int unsigned acc_w, input bit signed_en);
      if (signed_en) begin
         return (32'd1 << (acc_w - 32'd1)) - 32'd1;
      end
      return (32'd1 << acc_w) - 32'd1;
   endfunction

   // Lower clamp value; two's-complement pattern in signed mode.
   function automatic logic [31:0] sat_lo(input int unsigned acc_w, input bit signed_en);
      if (signed_en) begin
         return ~((32'd1 << (acc_w - 32'd1)) - 32'd1);
      end
      return 32'd0;
   endfunction

endpackage

// File: rtl/perceptron_ctrl_add3_sat.sv
// Combinational saturating adder: acc plus two optionally-gated weights.
// Signedness follows PERCEPTRON_SIGNED_EN.
module add3_sat
   import perceptron_pkg::*;
#(
   parameter int unsigned W_W   = WWDefault,
   parameter int unsigned ACC_W = AccWDefault
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [W_W-1:0]   wa_i,
   input  logic [W_W-1:0]   wb_i,
   input  logic             ena_i,
   input  logic             enb_i,
   output logic [ACC_W-1:0] sum_o
);

   // Two guard bits hold any acc + 2*weight result without overflow.
   localparam int unsigned ExtW = ACC_W + 2;
   localparam logic [31:0] Hi32 = sat_hi(ACC_W, SignedEn);
   localparam logic [31:0] Lo32 = sat_lo(ACC_W, SignedEn);
   localparam logic [ExtW-1:0] Hi = Hi32[ExtW-1:0];
   localparam logic [ExtW-1:0] Lo = Lo32[ExtW-1:0];

   logic [ExtW-1:0] acc_x;
   logic [ExtW-1:0] wa_x;
   logic [ExtW-1:0] wb_x;
   logic [ExtW-1:0] total;
   logic            ov_hi;
   logic            ov_lo;

   always_comb begin
`ifdef PERCEPTRON_SIGNED_EN
      acc_x = {{2{acc_i[ACC_W-1]}}, acc_i};
      wa_x  = ena_i ? {{(ExtW-W_W){wa_i[W_W-1]}}, wa_i} : '0;
      wb_x  = enb_i ? {{(ExtW-W_W){wb_i[W_W-1]}}, wb_i} : '0;
      total = acc_x + wa_x + wb_x;
      ov_hi = $signed(total) > $signed(Hi);
      ov_lo = $signed(total) < $signed(Lo);
`else
      acc_x = {2'b00, acc_i};
      wa_x  = ena_i ? {{(ExtW-W_W){1'b0}}, wa_i} : '0;
      wb_x  = enb_i ? {{(ExtW-W_W){1'b0}}, wb_i} : '0;
      total = acc_x + wa_x + wb_x;
      ov_hi = total > Hi;
      ov_lo = 1'b0;
`endif
      if (ov_hi) begin
         sum_o = Hi[ACC_W-1:0];
      end else if (ov_lo) begin
         sum_o = Lo[ACC_W-1:0];
      end else begin
         sum_o = total[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/perceptron_ctrl.sv
// Perceptron evaluation sequencer: two gated weights per cycle into a saturating
// accumulator, then a threshold compare. Build option: PERCEPTRON_SIGNED_EN.
module perceptron_ctrl
   import perceptron_pkg::*;
#(
   parameter int unsigned N_IN  = NInDefault,
   parameter int unsigned W_W   = WWDefault,
   parameter int unsigned ACC_W = AccWDefault
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [N_IN-1:0]     x_i,
   input  logic [N_IN*W_W-1:0] w_i,
   input  logic [ACC_W-1:0]    theta_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [ACC_W-1:0]    sum_o,
   output logic                y_o
);

   localparam int unsigned IdxW = $clog2(N_IN);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(N_IN - 2);

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [N_IN-1:0]     x_q, x_d;
   logic [N_IN*W_W-1:0] w_q, w_d;
   logic [ACC_W-1:0]    theta_q, theta_d;
   logic [ACC_W-1:0]    sum_q, sum_d;
   logic                y_q, y_d;
   logic                done_q, done_d;

   logic [W_W-1:0]      w_arr [N_IN];
   logic [IdxW-1:0]     idx_hi;
   logic [ACC_W-1:0]    acc_next;
   logic                ge;

   always_comb begin
      for (int i = 0; i < int'(N_IN); i++) begin
         w_arr[i] = w_q[i*W_W +: W_W];
      end
   end

   // idx is always even, so the pair partner is idx+1.
   assign idx_hi = idx_q + IdxW'(1);

   add3_sat #(
      .W_W   (W_W),
      .ACC_W (ACC_W)
   ) u_add3_sat (
      .acc_i (acc_q),
      .wa_i  (w_arr[idx_q]),
      .wb_i  (w_arr[idx_hi]),
      .ena_i (x_q[idx_q]),
      .enb_i (x_q[idx_hi]),
      .sum_o (acc_next)
   );

`ifdef PERCEPTRON_SIGNED_EN
   assign ge = $signed(acc_q) >= $signed(theta_q);
`else
   assign ge = acc_q >= theta_q;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      x_d     = x_q;
      w_d     = w_q;
      theta_d = theta_q;
      sum_d   = sum_q;
      y_d     = y_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               x_d     = x_i;
               w_d     = w_i;
               theta_d = theta_i;
               acc_d   = '0;
               idx_d   = '0;
               state_d = StAcc;
            end
         end
         StAcc: begin
            acc_d = acc_next;
            idx_d = idx_q + IdxW'(2);
            if (idx_q == IdxLast) begin
               state_d = StCmp;
            end
         end
         StCmp: begin
            sum_d   = acc_q;
            y_d     = ge;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         w_q     <= '0;
         theta_q <= '0;
         sum_q   <= '0;
         y_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         w_q     <= w_d;
         theta_q <= theta_d;
         sum_q   <= sum_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q != StIdle);
   assign done_o = done_q;
   assign sum_o  = sum_q;
   assign y_o    = y_q;

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed bench for perceptron_ctrl: default 8-input instance plus a 16-input,
// 6-bit-accumulator instance for saturation (and signed mode when enabled).
module tb_perceptron_ctrl;

   localparam logic [31:0] WInc = 32'h8765_4321;  // weight i = i+1

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  x;
   logic [31:0] w;
   logic [7:0]  theta;
   logic        busy;
   logic        done;
   logic [7:0]  sum;
   logic        y;

   logic        start2;
   logic [15:0] x2;
   logic [63:0] w2;
   logic [5:0]  theta2;
   logic        busy2;
   logic        done2;
   logic [5:0]  sum2;
   logic        y2;

   int checks;
   int errors;

   perceptron_ctrl #(
      .N_IN  (8),
      .W_W   (4),
      .ACC_W (8)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .x_i     (x),
      .w_i     (w),
      .theta_i (theta),
      .busy_o  (busy),
      .done_o  (done),
      .sum_o   (sum),
      .y_o     (y)
   );

   perceptron_ctrl #(
      .N_IN  (16),
      .W_W   (4),
      .ACC_W (6)
   ) dut2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start2),
      .x_i     (x2),
      .w_i     (w2),
      .theta_i (theta2),
      .busy_o  (busy2),
      .done_o  (done2),
      .sum_o   (sum2),
      .y_o     (y2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Starts a job on dut, scrambles inputs after the start edge, returns cycles to done.
   task automatic run_job(input logic [7:0] xv, input logic [7:0] th, output int lat);
      @(posedge clk); #1;
      x = xv; theta = th; w = WInc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; x = ~xv; theta = ~th; w = '0;
      lat = 0;
      while (done !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_job2(input logic [15:0] xv, input logic [63:0] wv,
                           input logic [5:0] th, output int lat);
      @(posedge clk); #1;
      x2 = xv; w2 = wv; theta2 = th; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0; x2 = '0; w2 = '0; theta2 = '0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; x = '0; w = '0; theta = '0;
      start2 = 1'b0; x2 = '0; w2 = '0; theta2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, sum, y} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%0d y=%b want all 0",
                  busy, done, sum, y);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, sum, y} !== 11'd0 || busy2 !== 1'b0 || sum2 !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b sum=%0d y=%b want all 0",
                  busy, done, sum, y);
      end
   endtask

   task automatic test_full_sum;
      int lat;
      run_job(8'hFF, 8'd36, lat);
      checks++;
      if (lat !== 5) begin
         errors++; $display("FAIL full_latency: got %0d want 5", lat);
      end
      checks++;
      if (sum !== 8'd36 || y !== 1'b1) begin
         errors++; $display("FAIL full_sum36: got sum=%0d y=%b want 36 1", sum, y);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL busy_at_done: got %b want 0", busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse_width: got %b want 0", done);
      end
      run_job(8'hFF, 8'd37, lat);
      checks++;
      if (sum !== 8'd36 || y !== 1'b0) begin
         errors++; $display("FAIL full_sum37: got sum=%0d y=%b want 36 0", sum, y);
      end
   endtask

   task automatic test_sparse;
      int lat;
      run_job(8'b1010_0101, 8'd20, lat);
      checks++;
      if (lat !== 5 || sum !== 8'd18 || y !== 1'b0) begin
         errors++;
         $display("FAIL sparse: got lat=%0d sum=%0d y=%b want 5 18 0", lat, sum, y);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (sum !== 8'd18 || y !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL sparse_hold: got sum=%0d y=%b done=%b want 18 0 0", sum, y, done);
      end
   endtask

   task automatic test_zero;
      int lat;
      run_job(8'h00, 8'd0, lat);
      checks++;
      if (sum !== 8'd0 || y !== 1'b1) begin
         errors++; $display("FAIL zero_th0: got sum=%0d y=%b want 0 1", sum, y);
      end
      run_job(8'h00, 8'd1, lat);
      checks++;
      if (sum !== 8'd0 || y !== 1'b0) begin
         errors++; $display("FAIL zero_th1: got sum=%0d y=%b want 0 0", sum, y);
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      bit extra;
      @(posedge clk); #1;
      x = 8'hFF; theta = 8'd36; w = WInc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      x = 8'h01; theta = 8'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 3;
      while (done !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 5 || sum !== 8'd36 || y !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start: got lat=%0d sum=%0d y=%b want 5 36 1", lat, sum, y);
      end
      extra = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++; $display("FAIL ignore_no_queue: got extra job=%b want 0", extra);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      bit seen;
      run_job(8'hFF, 8'd36, lat);
      @(posedge clk); #1;
      x = 8'hFF; theta = 8'd0; w = WInc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || sum !== 8'd0 || y !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b sum=%0d y=%b done=%b want 0 0 0 0",
                  busy, sum, y, done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_no_done: got done_seen=%b busy=%b want 0 0", seen, busy);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(posedge clk); #1;
      x = 8'hFF; theta = 8'd36; w = WInc; start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (done !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 5 || sum !== 8'd36) begin
         errors++; $display("FAIL b2b_first: got lat=%0d sum=%0d want 5 36", lat, sum);
      end
      x = 8'h0F;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 5 || sum !== 8'd10 || y !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d sum=%0d y=%b want 5 10 0", lat, sum, y);
      end
   endtask

`ifdef PERCEPTRON_SIGNED_EN
   task automatic test_signed;
      int lat;
      run_job2(16'h00FF, {16{4'b1000}}, 6'b100000, lat);
      checks++;
      if (lat !== 9 || sum2 !== 6'b100000 || y2 !== 1'b1) begin
         errors++;
         $display("FAIL signed_sat: got lat=%0d sum=%b y=%b want 9 100000 1", lat, sum2, y2);
      end
      run_job2(16'h00FF, {16{4'b1000}}, 6'b100001, lat);
      checks++;
      if (sum2 !== 6'b100000 || y2 !== 1'b0) begin
         errors++; $display("FAIL signed_cmp: got sum=%b y=%b want 100000 0", sum2, y2);
      end
   endtask
`else
   task automatic test_saturation;
      int lat;
      run_job2(16'hFFFF, {16{4'hF}}, 6'd63, lat);
      checks++;
      if (lat !== 9 || sum2 !== 6'd63 || y2 !== 1'b1 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL saturation: got lat=%0d sum=%0d y=%b want 9 63 1", lat, sum2, y2);
      end
      run_job2(16'h0003, {16{4'hF}}, 6'd31, lat);
      checks++;
      if (sum2 !== 6'd30 || y2 !== 1'b0) begin
         errors++; $display("FAIL sat_partial: got sum=%0d y=%b want 30 0", sum2, y2);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full_sum();
      test_sparse();
      test_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
`ifdef PERCEPTRON_SIGNED_EN
      test_signed();
`else
      test_saturation();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
